// File: rtl/calc_pkg.sv
// Shared encodings for the calculator datapath: operators, phase bit positions, control states.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    localparam int PH_A   = 0;
    localparam int PH_B   = 1;
    localparam int PH_OP  = 2;
    localparam int PH_RES = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DIV  = 2'b10,
        HOLD = 2'b11
    } state_t;

endpackage

// File: rtl/calc_datapath_div_seq.sv
// Purpose: unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: W cycles after start; valid and the final quotient/remainder appear combinationally in the Wth cycle.
// Backpressure: none; abort drops an in-flight division.
module div_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         valid
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic          run;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    // Outputs are this cycle's iteration result, so the caller can latch them on the last edge.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[W]) begin
            remainder = diff[W-1:0];
            quotient  = {quo_q[W-2:0], 1'b1};
        end else begin
            remainder = shifted[W-1:0];
            quotient  = {quo_q[W-2:0], 1'b0};
        end
        valid = run && (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= 1'b0;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (abort) begin
            run <= 1'b0;
        end else if (run) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_datapath.sv
// Purpose: capture operands/operator per sequencer phase and compute the 2W-bit result.
// Latency: add/sub/mul/div-by-zero 1 cycle after the result-phase edge, division W cycles.
// Backpressure: none; result and done are levels held until the next operand-A phase.
module calc_datapath #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     phase,
    input  logic [W-1:0]   sw,
    input  logic [1:0]     op_sel,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    output logic [2*W-1:0] result,
    output logic           neg,
    output logic           err,
    output logic           busy,
    output logic           done
);

    import calc_pkg::*;

    state_t         state;
    state_t         state_n;
    op_t            op_q;
    logic           res_d;
    logic           phase_ok;
    logic           res_on;
    logic           start;
    logic           div_start;
    logic           div_abort;
    logic           div_valid;
    logic [W-1:0]   div_quo;
    logic [W-1:0]   div_rem;
    logic           wr_res;
    logic [2*W-1:0] res_n;
    logic           neg_n;
    logic           err_n;
    logic [2*W-1:0] a_x;
    logic [2*W-1:0] b_x;
    logic [2*W-1:0] alu_res;
    logic           alu_neg;
    logic           alu_err;

    // The sequencer is unreset, so anything that is not exactly one-hot is ignored.
    assign phase_ok  = (phase != 4'b0000) && ((phase & (phase - 4'd1)) == 4'b0000);
    assign res_on    = phase_ok && phase[PH_RES];
    assign start     = (state == IDLE) && res_on && !res_d;
    assign div_abort = (state == DIV) && !res_on;
    assign busy      = (state == CALC) || (state == DIV);
    assign done      = (state == HOLD);

    assign a_x = {{W{1'b0}}, op_a};
    assign b_x = {{W{1'b0}}, op_b};

    always_comb begin
        alu_res = '0;
        alu_neg = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: alu_res = a_x + b_x;
            OP_SUB: begin
                if (op_a < op_b) begin
                    alu_res = b_x - a_x;
                    alu_neg = 1'b1;
                end else begin
                    alu_res = a_x - b_x;
                end
            end
            OP_MUL: alu_res = a_x * b_x;
            // Division only reaches CALC with a zero divisor.
            OP_DIV: alu_err = 1'b1;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_n   = state;
        wr_res    = 1'b0;
        res_n     = result;
        neg_n     = 1'b0;
        err_n     = 1'b0;
        div_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((op_q == OP_DIV) && (op_b != '0)) begin
                        state_n   = DIV;
                        div_start = 1'b1;
                    end else begin
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                if (!res_on) begin
                    state_n = IDLE;
                end else begin
                    state_n = HOLD;
                    wr_res  = 1'b1;
                    res_n   = alu_res;
                    neg_n   = alu_neg;
                    err_n   = alu_err;
                end
            end
            DIV: begin
                if (!res_on) begin
                    state_n = IDLE;
                end else if (div_valid) begin
                    state_n = HOLD;
                    wr_res  = 1'b1;
                    res_n   = {div_rem, div_quo};
                end
            end
            HOLD: begin
                if (!phase[PH_RES]) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_q   <= OP_ADD;
            result <= '0;
            neg    <= 1'b0;
            err    <= 1'b0;
            res_d  <= 1'b0;
        end else begin
            res_d <= phase[PH_RES];
            if (phase == (4'b0001 << PH_A)) begin
                op_a   <= sw;
                result <= '0;
                neg    <= 1'b0;
                err    <= 1'b0;
            end
            if (phase == (4'b0001 << PH_B)) begin
                op_b <= sw;
            end
            if (phase == (4'b0001 << PH_OP)) begin
                op_q <= op_t'(op_sel);
            end
            if (wr_res) begin
                result <= res_n;
                neg    <= neg_n;
                err    <= err_n;
            end
        end
    end

    div_seq #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (div_abort),
        .dividend  (op_a),
        .divisor   (op_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

endmodule

// File: tb/tb_calc_datapath.sv
// Directed bench for calc_datapath: capture, each operator, divide-by-zero, abort, reset and invalid phases.
module tb_calc_datapath;

    logic       clk;
    logic       rst;
    logic [3:0] phase;
    logic [3:0] sw;
    logic [1:0] op_sel;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [7:0] result;
    logic       neg;
    logic       err;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    calc_datapath #(.W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .phase  (phase),
        .sw     (sw),
        .op_sel (op_sel),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (result),
        .neg    (neg),
        .err    (err),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs phases A, B, operator; leaves phase at the result phase edge (E0) just sampled.
    task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        rst = 1'b0;
        phase = 4'b0001; sw = a;  tick();
        phase = 4'b0010; sw = b;  tick();
        phase = 4'b0100; op_sel = op; tick();
        phase = 4'b1000; tick();
    endtask

    initial begin
        rst = 1'b1; phase = 4'b0000; sw = 4'd0; op_sel = 2'b00;
        tick();
        chk("rst_op_a",   16'(op_a),   16'd0);
        chk("rst_op_b",   16'(op_b),   16'd0);
        chk("rst_result", 16'(result), 16'd0);
        chk("rst_flags",  16'({neg, err, busy, done}), 16'd0);

        // Add 7+3
        rst = 1'b0;
        phase = 4'b0001; sw = 4'd7; tick();
        chk("cap_a", 16'(op_a), 16'd7);
        phase = 4'b0010; sw = 4'd3; tick();
        chk("cap_b", 16'(op_b), 16'd3);
        phase = 4'b0100; op_sel = 2'b00; tick();
        phase = 4'b1000; tick();
        chk("add_e0_busy", 16'({busy, done}), 16'b10);
        tick();
        chk("add_result", 16'(result), 16'd10);
        chk("add_done",   16'({busy, done, neg, err}), 16'b0100);
        tick();
        chk("add_hold", 16'({result, done}), {7'd0, 8'd10, 1'b1});

        // Operand-A phase clears the held result
        phase = 4'b0001; sw = 4'd3; tick();
        chk("clr_result", 16'({result, done}), 16'd0);

        // Subtraction both ways
        load(4'd3, 4'd9, 2'b01);
        tick();
        chk("sub_neg", 16'({result, neg}), {7'd0, 8'd6, 1'b1});
        load(4'd9, 4'd3, 2'b01);
        tick();
        chk("sub_pos", 16'({result, neg}), {7'd0, 8'd6, 1'b0});

        // Multiply 15*15
        load(4'd15, 4'd15, 2'b10);
        tick();
        chk("mul_result", 16'(result), 16'd225);
        chk("mul_done",   16'(done),   16'd1);

        // Divide 13/4: busy across E0..E0+3, result at E0+4
        load(4'd13, 4'd4, 2'b11);
        chk("div_e0_busy", 16'(busy), 16'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("div_iter_busy", 16'({busy, done}), 16'b10);
        end
        tick();
        chk("div_result", 16'(result), 16'h13);
        chk("div_done",   16'({busy, done}), 16'b01);

        // Abort: keep 0x13 held, reload b=5, drop result phase at E0+2
        phase = 4'b0100; op_sel = 2'b11; tick();
        chk("hold_exit", 16'({result, done}), {7'd0, 8'h13, 1'b0});
        phase = 4'b0010; sw = 4'd5; tick();
        phase = 4'b1000; tick();
        tick();
        chk("abort_pre_busy", 16'(busy), 16'd1);
        phase = 4'b0100; tick();
        chk("abort_idle", 16'({busy, done}), 16'b00);
        chk("abort_result", 16'(result), 16'h13);
        phase = 4'b1000; tick();
        for (int i = 0; i < 4; i++) begin
            chk("redo_busy", 16'({busy, done}), 16'b10);
            tick();
        end
        chk("redo_result", 16'(result), 16'h32);
        chk("redo_done",   16'(done),   16'd1);

        // Divide by zero goes through the one-cycle path
        load(4'd9, 4'd0, 2'b11);
        chk("dz_e0_busy", 16'(busy), 16'd1);
        tick();
        chk("dz_result", 16'(result), 16'd0);
        chk("dz_flags",  16'({busy, done, neg, err}), 16'b0101);

        // Invalid phase aborts a division in flight
        load(4'd13, 4'd4, 2'b11);
        phase = 4'b1100; tick();
        chk("inv_abort", 16'({busy, done}), 16'b00);

        // Reset mid-division
        load(4'd13, 4'd4, 2'b11);
        tick();
        rst = 1'b1; tick();
        chk("rst_mid_ops", 16'({op_a, op_b}), 16'd0);
        chk("rst_mid_out", 16'({result, neg, err, busy, done}), 16'd0);

        // Invalid phases capture nothing and never start
        rst = 1'b0;
        phase = 4'b0001; sw = 4'd5; tick();
        phase = 4'b0010; sw = 4'd6; tick();
        phase = 4'b0000; sw = 4'd9; tick();
        chk("inv0_ops", 16'({op_a, op_b}), 16'h56);
        phase = 4'b0101; sw = 4'd10; tick();
        chk("inv5_ops", 16'({op_a, op_b}), 16'h56);
        chk("inv5_busy", 16'(busy), 16'd0);
        phase = 4'b1010; sw = 4'd1; tick();
        chk("invA_nostart", 16'({busy, done}), 16'b00);
        chk("invA_ops", 16'({op_a, op_b}), 16'h56);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
